mmu_port_arbiter: RTL

Arbiter and sequencer placed in front of the MMU control block. It shares the single MMU request channel between the instruction-fetch port and the data port. It decodes each data access as on-chip or off-chip from its address, then holds exactly one MMU request in flight. It returns the MMU response to the granted requester, and a watchdog turns a hung MMU transaction into an error response.

---
 rtl/mmu_port_arbiter_if.sv | 48 ++++
 rtl/mmu_port_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mmu_port_arbiter_if.sv
// rtl/mmu_port_arbiter_if.sv - request/response bundle between the fetch/data ports, the arbiter and MMU control
// Ports: fetch port (i_*), data port (d_*), shared rsp_err, MMU control channel (mmu_*), busy.
//   slave  : arbiter side (consumes requests and mmu_resp, drives responses and strobes)
//   master : requester/MMU side (testbench or surrounding fabric)
interface mmu_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp;

    logic              rsp_err;

    logic              mmu_inst_req;
    logic              mmu_onc_read;
    logic              mmu_onc_write;
    logic              mmu_offc_read;
    logic              mmu_offc_write;
    logic [ADDR_W-1:0] mmu_addr;
    logic [DATA_W-1:0] mmu_wdata;
    logic              mmu_resp;
    logic [DATA_W-1:0] mmu_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, mmu_resp, mmu_rdata,
        output i_rdata, i_resp, d_rdata, d_resp, rsp_err,
        output mmu_inst_req, mmu_onc_read, mmu_onc_write, mmu_offc_read, mmu_offc_write,
        output mmu_addr, mmu_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata, mmu_resp, mmu_rdata,
        input  i_rdata, i_resp, d_rdata, d_resp, rsp_err,
        input  mmu_inst_req, mmu_onc_read, mmu_onc_write, mmu_offc_read, mmu_offc_write,
        input  mmu_addr, mmu_wdata, busy
    );
endinterface

// File: rtl/mmu_port_arbiter.sv
// rtl/mmu_port_arbiter.sv - shares the single MMU request channel between fetch and data ports
// Ports:
//   clk, rst   : clock; asynchronous active-high reset
//   bus.slave  : i_req/i_addr -> i_rdata/i_resp; d_read/d_write/d_addr/d_wdata -> d_rdata/d_resp;
//                rsp_err qualifies either resp (1 = watchdog expiry);
//                one-hot mmu_* strobes with latched mmu_addr/mmu_wdata, mmu_resp/mmu_rdata back;
//                busy high whenever not IDLE.
module mmu_port_arbiter #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  ONC_BASE  = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0]  ONC_LIMIT = ADDR_W'(32'h0000_FFFF),
    parameter int                 TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst,
    mmu_port_arbiter_if.slave   bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        K_INST,
        K_ONC_RD,
        K_ONC_WR,
        K_OFFC_RD,
        K_OFFC_WR
    } kind_t;

    state_t            state;
    state_t            state_nx;
    kind_t             kind_q;
    kind_t             grant_kind;

    logic              last_grant_data;
    logic              d_pend;
    logic              grant_valid;
    logic              grant_inst;
    logic              d_in_onc;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              to_hit_q;

    // Arbitration and decode, only meaningful in IDLE.
    // Offset-compare range check stays correct when ONC_BASE is zero.
    always_comb begin
        d_pend      = bus.d_read | bus.d_write;
        grant_valid = bus.i_req | d_pend;
        grant_inst  = bus.i_req & (~d_pend | last_grant_data);
        d_in_onc    = (bus.d_addr - ONC_BASE) <= (ONC_LIMIT - ONC_BASE);

        grant_kind = K_INST;
        if (!grant_inst) begin
            if (bus.d_write) begin
                grant_kind = d_in_onc ? K_ONC_WR : K_OFFC_WR;
            end else begin
                grant_kind = d_in_onc ? K_ONC_RD : K_OFFC_RD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Moore outputs: strobes come only from state and the latched kind.
    always_comb begin
        state_nx           = state;
        bus.busy           = 1'b0;
        bus.mmu_inst_req   = 1'b0;
        bus.mmu_onc_read   = 1'b0;
        bus.mmu_onc_write  = 1'b0;
        bus.mmu_offc_read  = 1'b0;
        bus.mmu_offc_write = 1'b0;
        bus.i_resp         = 1'b0;
        bus.d_resp         = 1'b0;
        bus.rsp_err        = 1'b0;

        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                bus.busy           = 1'b1;
                bus.mmu_inst_req   = (kind_q == K_INST);
                bus.mmu_onc_read   = (kind_q == K_ONC_RD);
                bus.mmu_onc_write  = (kind_q == K_ONC_WR);
                bus.mmu_offc_read  = (kind_q == K_OFFC_RD);
                bus.mmu_offc_write = (kind_q == K_OFFC_WR);
                if (bus.mmu_resp || to_hit_q) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                bus.busy    = 1'b1;
                bus.i_resp  = (kind_q == K_INST);
                bus.d_resp  = (kind_q != K_INST);
                bus.rsp_err = err_q;
                state_nx    = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // The expiry compare is registered, so the error path leaves REQ one cycle
    // after the counter reaches TIMEOUT-1; a response arriving in that extra
    // cycle still beats the error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q          <= K_INST;
            last_grant_data <= 1'b1;
            addr_q          <= '0;
            wdata_q         <= '0;
            i_rdata_q       <= '0;
            d_rdata_q       <= '0;
            err_q           <= 1'b0;
            cnt_q           <= '0;
            to_hit_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        kind_q          <= grant_kind;
                        last_grant_data <= ~grant_inst;
                        addr_q          <= grant_inst ? bus.i_addr : bus.d_addr;
                        wdata_q         <= grant_inst ? '0 : bus.d_wdata;
                        cnt_q           <= '0;
                        to_hit_q        <= 1'b0;
                    end
                end
                S_REQ: begin
                    cnt_q    <= cnt_q + 1'b1;
                    to_hit_q <= (cnt_q == CNT_LAST);
                    if (bus.mmu_resp) begin
                        err_q <= 1'b0;
                        if (kind_q == K_INST) begin
                            i_rdata_q <= bus.mmu_rdata;
                        end else begin
                            d_rdata_q <= bus.mmu_rdata;
                        end
                    end else if (to_hit_q) begin
                        err_q <= 1'b1;
                        if (kind_q == K_INST) begin
                            i_rdata_q <= '0;
                        end else begin
                            d_rdata_q <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mmu_addr  = addr_q;
    assign bus.mmu_wdata = wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule
